matrix_alu_responder: RTL

Bus responder for the matrix arithmetic unit: the slave at enable code 3 on the execution engine's 16-bit address bus. It accepts operand A and operand B writes, starts the operation named by the opcode in the address location field, and returns the 4x4 result on a 256-bit read port within the engine's two-cycle read-back window. It is a peer of main memory (enable 0), instruction memory (enable 2) and the integer ALU (enable 5).

---
 rtl/matrix_alu_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/matrix_alu_responder.sv
// Matrix arithmetic bus responder (enable code 3): operand A/B registers, one-cycle compute, 256-bit read-back.
// Optional build macro MATRIX_ALU_SATURATE_EN: clamp add/sub/multiply/scale results instead of wrapping.
module matrix_alu_responder (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [15:0]  address,
    input  logic [255:0] ExeDataOut,
    input  logic         nRead,
    input  logic         nWrite,
    output logic [255:0] MatrixDataOut,
    output logic         MatrixValid,
    output logic         MatrixErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state_q;
    logic [255:0]   a_q, b_q, res_q, res_d;
    logic [7:0]     op_q;
    logic           valid_q, err_q, err_d;
    logic           selected, wr_a, wr_b;
    logic [15:0]    val;
`ifdef MATRIX_ALU_SATURATE_EN
    logic [33:0]    acc;
    logic [31:0]    prod;
    logic [16:0]    sum17;
`endif

    function automatic logic [15:0] el(input logic [255:0] m, input int unsigned r, input int unsigned c);
        return m[16*(4*r+c) +: 16];
    endfunction

    assign selected = (address[15:12] == 4'd3);
    assign wr_a     = selected && !nWrite && (address[11:8] == 4'd0);
    assign wr_b     = selected && !nWrite && (address[11:8] == 4'd1);

    // Result is a pure function of the registered operands; writes in the COMPUTE cycle land after it.
    always_comb begin
        res_d = '0;
        val   = '0;
`ifdef MATRIX_ALU_SATURATE_EN
        acc   = '0;
        prod  = '0;
        sum17 = '0;
`endif
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                val = '0;
                case (op_q)
                    8'h00: begin
`ifdef MATRIX_ALU_SATURATE_EN
                        acc = '0;
                        for (int unsigned k = 0; k < 4; k++) begin
                            prod = {16'h0, el(a_q, r, k)} * {16'h0, el(b_q, k, c)};
                            acc  = acc + {2'b00, prod};
                        end
                        val = (acc > 34'h0_0000_FFFF) ? 16'hFFFF : acc[15:0];
`else
                        for (int unsigned k = 0; k < 4; k++)
                            val = val + el(a_q, r, k) * el(b_q, k, c);
`endif
                    end
                    8'h01: begin
`ifdef MATRIX_ALU_SATURATE_EN
                        sum17 = {1'b0, el(a_q, r, c)} + {1'b0, el(b_q, r, c)};
                        val   = sum17[16] ? 16'hFFFF : sum17[15:0];
`else
                        val = el(a_q, r, c) + el(b_q, r, c);
`endif
                    end
                    8'h02: begin
`ifdef MATRIX_ALU_SATURATE_EN
                        val = (el(a_q, r, c) < el(b_q, r, c)) ? 16'h0000
                                                              : el(a_q, r, c) - el(b_q, r, c);
`else
                        val = el(a_q, r, c) - el(b_q, r, c);
`endif
                    end
                    8'h03: val = el(a_q, c, r);
                    8'h04: begin
`ifdef MATRIX_ALU_SATURATE_EN
                        prod = {16'h0, el(a_q, r, c)} * {16'h0, el(b_q, 0, 0)};
                        val  = (prod[31:16] != 16'h0) ? 16'hFFFF : prod[15:0];
`else
                        val = el(a_q, r, c) * el(b_q, 0, 0);
`endif
                    end
                    default: val = '0;
                endcase
                res_d[16*(4*r+c) +: 16] = val;
            end
        end
        err_d = (op_q > 8'h04);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (wr_a)
                a_q <= ExeDataOut;
            if (state_q == COMPUTE) begin
                res_q   <= res_d;
                err_q   <= err_d;
                state_q <= DONE;
                valid_q <= 1'b1;
            end
            // A B write takes priority over completion so COMPUTE re-arms with the new opcode.
            if (wr_b) begin
                b_q     <= ExeDataOut;
                op_q    <= address[7:0];
                state_q <= COMPUTE;
                valid_q <= 1'b0;
            end
        end
    end

    assign MatrixDataOut = (selected && !nRead) ? res_q : '0;
    assign MatrixValid   = valid_q;
    assign MatrixErr     = err_q;

endmodule
